noc_pm_in_fifo_wr: RTL and testbench

- Write half of the NoC-to-PM asynchronous packet FIFO. Sits in the NoC clock domain, directly upstream of the PM module's inbound FIFO interface.
- Accepts NoC packets over a valid/ready handshake and stores them in a 2^AWIDTH-entry register array.
- Exports a Gray-coded write pointer and the packet addressed by the reader's Gray read pointer, which arrives from the PM domain.
- Synchronises the read pointer locally to generate full/back-pressure.

---
 rtl/noc_pm_in_fifo_wr.sv | 95 +++++++++
 tb/tb_noc_pm_in_fifo_wr.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pm_in_fifo_wr.sv
// noc_pm_in_fifo_wr: NoC-domain write half of the NoC-to-PM asynchronous packet FIFO.
// Ports: clk_noc_i/reset_noc_i (sync, active-high); noc_pkt_i/noc_valid_i/noc_ready_o enqueue
// handshake; noc_fifo_pm_in_data_o entry at the reader's pointer; noc_fifo_pm_in_raddr_i Gray read
// pointer from the PM domain; noc_fifo_pm_in_waddr_o registered Gray write pointer;
// fill_level_o/stall_cnt_o statistics, live only when NOC_PM_IN_FIFO_STATS_EN is defined.
module noc_pm_in_fifo_wr #(
  parameter int NOC_ASYNC_FIFO_PACKET_SIZE = 32,
  parameter int NOC_ASYNC_FIFO_AWIDTH      = 2,
  parameter int SYNC_STAGES                = 2
) (
  input  logic                                  clk_noc_i,
  input  logic                                  reset_noc_i,
  input  logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] noc_pkt_i,
  input  logic                                  noc_valid_i,
  output logic                                  noc_ready_o,
  output logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] noc_fifo_pm_in_data_o,
  input  logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_in_raddr_i,
  output logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_in_waddr_o,
  output logic [NOC_ASYNC_FIFO_AWIDTH:0]        fill_level_o,
  output logic [15:0]                           stall_cnt_o
);
  localparam int AW = NOC_ASYNC_FIFO_AWIDTH;
  localparam int PW = NOC_ASYNC_FIFO_PACKET_SIZE;
  localparam int DEPTH = 1 << AW;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d, rs, rbin;
  logic [AW:0] rsync_q [SYNC_STAGES];
  logic [PW-1:0] mem_q [DEPTH];
  logic full, accept;

  always_comb begin
    rs = rsync_q[SYNC_STAGES-1];
    // Full when the pointers differ only in the wrap bit, which in Gray form flips the top two bits.
    full = wgray_q == {~rs[AW:AW-1], rs[AW-2:0]};
    noc_ready_o = ~full & ~reset_noc_i;
    accept = noc_valid_i & noc_ready_o;
    wbin_d = accept ? wbin_q + 1'b1 : wbin_q;
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Unsynchronised on purpose: the addressed entry is never written while the reader points at it.
    rbin = gray2bin(noc_fifo_pm_in_raddr_i);
    noc_fifo_pm_in_data_o = mem_q[rbin[AW-1:0]];
  end

  assign noc_fifo_pm_in_waddr_o = wgray_q;

  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      wbin_q <= '0;
      wgray_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
    end else begin
      wbin_q <= wbin_d;
      wgray_q <= wgray_d;
      rsync_q[0] <= noc_fifo_pm_in_raddr_i;
      for (int i = 1; i < SYNC_STAGES; i++) rsync_q[i] <= rsync_q[i-1];
    end
  end

  always_ff @(posedge clk_noc_i) begin
    if (accept) mem_q[wbin_q[AW-1:0]] <= noc_pkt_i;
  end

`ifdef NOC_PM_IN_FIFO_STATS_EN
  logic [AW:0] fill_q, fill_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    fill_d = wbin_q - gray2bin(rs);
    stall_d = (noc_valid_i & ~noc_ready_o & ~&stall_q) ? stall_q + 16'd1 : stall_q;
  end

  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      fill_q <= '0;
      stall_q <= '0;
    end else begin
      fill_q <= fill_d;
      stall_q <= stall_d;
    end
  end

  assign fill_level_o = fill_q;
  assign stall_cnt_o = stall_q;
`else
  assign fill_level_o = '0;
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_noc_pm_in_fifo_wr.sv
// tb_noc_pm_in_fifo_wr: randomized self-checking bench for noc_pm_in_fifo_wr against a count/queue model.
module tb_noc_pm_in_fifo_wr;
  localparam int PW = 32;
  localparam int AW = 2;

  logic clk = 0;
  logic rst = 1;
  logic valid = 0;
  logic [PW-1:0] pkt = '0;
  logic ready;
  logic [PW-1:0] data;
  logic [AW:0] raddr = '0;
  logic [AW:0] waddr;
  logic [AW:0] fill;
  logic [15:0] stall;

  always #5 clk = ~clk;

  noc_pm_in_fifo_wr #(
    .NOC_ASYNC_FIFO_PACKET_SIZE(PW),
    .NOC_ASYNC_FIFO_AWIDTH(AW),
    .SYNC_STAGES(2)
  ) dut (
    .clk_noc_i(clk),
    .reset_noc_i(rst),
    .noc_pkt_i(pkt),
    .noc_valid_i(valid),
    .noc_ready_o(ready),
    .noc_fifo_pm_in_data_o(data),
    .noc_fifo_pm_in_raddr_i(raddr),
    .noc_fifo_pm_in_waddr_o(waddr),
    .fill_level_o(fill),
    .stall_cnt_o(stall)
  );

  int tests = 0;
  int fails = 0;
  // Model: write count, reader count, reader count as seen 1 and 2 edges later.
  int wcnt = 0;
  int rcnt = 0;
  int s1 = 0;
  int s2 = 0;
  int stall_m = 0;
  logic [PW-1:0] mem_m [4];
  logic [PW-1:0] sb [$];

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic bit m_ready();
    return !rst && (((wcnt - s2) & 7) != 4);
  endfunction

  task automatic cycle();
    bit acc;
    acc = valid && m_ready();
    if (rst) begin
      wcnt = 0;
      s1 = 0;
      s2 = 0;
      stall_m = 0;
      sb.delete();
    end else begin
      if (valid && !acc && stall_m < 65535) stall_m++;
      if (acc) begin
        mem_m[wcnt % 4] = pkt;
        sb.push_back(pkt);
        wcnt = (wcnt + 1) & 7;
      end
      s2 = s1;
      s1 = rcnt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    valid = 0;
    rcnt = 0;
    raddr = '0;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    valid = 1;
    pkt = $urandom;
    cycle();
    cycle();
    #2;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", ready); end
    tests++; if (waddr !== 3'd0) begin fails++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    valid = 0;
    rst = 0;
    #2;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b exp=1", ready); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      valid = 1;
      pkt = $urandom;
      #2;
      tests++; if (ready !== m_ready() || ready !== 1'b1) begin fails++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, ready); end
      tests++; if (waddr !== gray(wcnt)) begin fails++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, waddr, gray(wcnt)); end
      cycle();
    end
    tests++; if (waddr !== 3'd6) begin fails++; $display("FAIL fill_waddr_4 got=%0d exp=6", waddr); end
    for (int i = 0; i < 3; i++) begin
      pkt = $urandom;
      #2;
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL full_ready[%0d] got=%b exp=0", i, ready); end
      cycle();
      tests++; if (waddr !== 3'd6) begin fails++; $display("FAIL full_hold_waddr[%0d] got=%0d exp=6", i, waddr); end
    end
    valid = 0;
  endtask

  task automatic test_read_data();
    for (int i = 0; i < 4; i++) begin
      raddr = gray(i);
      #2;
      tests++; if (data !== mem_m[i]) begin fails++; $display("FAIL read_data[%0d] got=%h exp=%h", i, data, mem_m[i]); end
    end
    raddr = gray(rcnt);
    #2;
  endtask

  task automatic test_drain_release();
    logic [PW-1:0] a4;
    a4 = $urandom;
    rcnt = 1;
    raddr = gray(1);
    valid = 1;
    pkt = a4;
    #2;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL drain_ready_e0 got=%b exp=0", ready); end
    cycle();
    tests++; if (ready !== 1'b0 || waddr !== 3'd6) begin fails++; $display("FAIL drain_ready_e1 got=%b/%0d exp=0/6", ready, waddr); end
    cycle();
    tests++; if (ready !== 1'b1 || ready !== m_ready()) begin fails++; $display("FAIL drain_ready_e2 got=%b exp=1", ready); end
    cycle();
    valid = 0;
    tests++; if (waddr !== gray(5)) begin fails++; $display("FAIL drain_waddr got=%0d exp=%0d", waddr, gray(5)); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL drain_refull got=%b exp=0", ready); end
    raddr = gray(4);
    #2;
    tests++; if (data !== a4) begin fails++; $display("FAIL drain_slot0 got=%h exp=%h", data, a4); end
    raddr = gray(rcnt);
    #2;
  endtask

  task automatic test_wrap();
    int acc_n;
    int cyc;
    bit saw4;
    bit back0;
    logic [AW:0] prev;
    do_reset();
    acc_n = 0;
    cyc = 0;
    saw4 = 0;
    back0 = 0;
    prev = waddr;
    while (acc_n < 20 && cyc < 400) begin
      valid = $urandom_range(0, 3) != 0;
      pkt = $urandom;
      if (rcnt != wcnt && $urandom_range(0, 1) == 1) begin
        tests++; if (data !== sb[0]) begin fails++; $display("FAIL wrap_data[%0d] got=%h exp=%h", cyc, data, sb[0]); end
        void'(sb.pop_front());
        rcnt = (rcnt + 1) & 7;
        raddr = gray(rcnt);
      end
      #2;
      tests++; if (ready !== m_ready()) begin fails++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", cyc, ready, m_ready()); end
      if (valid && m_ready()) acc_n++;
      cycle();
      tests++; if (waddr !== gray(wcnt)) begin fails++; $display("FAIL wrap_waddr[%0d] got=%0d exp=%0d", cyc, waddr, gray(wcnt)); end
      if (waddr != prev) begin
        tests++; if ($countones(waddr ^ prev) != 1) begin fails++; $display("FAIL wrap_gray_step got=%b->%b exp=one-bit", prev, waddr); end
      end
      if (waddr == 3'd4) saw4 = 1;
      if (saw4 && waddr == 3'd0) back0 = 1;
      prev = waddr;
      cyc++;
    end
    valid = 0;
    tests++; if (acc_n != 20) begin fails++; $display("FAIL wrap_timeout got=%0d exp=20", acc_n); end
    tests++; if (!(saw4 && back0)) begin fails++; $display("FAIL wrap_seen got=%b%b exp=11", saw4, back0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      valid = 1;
      pkt = $urandom;
      cycle();
    end
    valid = 0;
    tests++; if (waddr !== gray(2)) begin fails++; $display("FAIL mid_pre_waddr got=%0d exp=%0d", waddr, gray(2)); end
    rst = 1;
    #2;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_ready_rst got=%b exp=0", ready); end
    cycle();
    tests++; if (waddr !== 3'd0) begin fails++; $display("FAIL mid_waddr got=%0d exp=0", waddr); end
    rst = 0;
    #2;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL mid_ready_post got=%b exp=1", ready); end
  endtask

  task automatic test_stats();
    do_reset();
    valid = 1;
    for (int i = 0; i < 4; i++) begin
      pkt = $urandom;
      cycle();
    end
    for (int i = 0; i < 5; i++) cycle();
    valid = 0;
    #2;
`ifdef NOC_PM_IN_FIFO_STATS_EN
    tests++; if (stall !== 16'd5 || stall !== 16'(stall_m)) begin fails++; $display("FAIL stats_stall got=%0d exp=5", stall); end
    tests++; if (fill !== 3'd4) begin fails++; $display("FAIL stats_fill got=%0d exp=4", fill); end
`else
    tests++; if (stall !== 16'd0) begin fails++; $display("FAIL stats_stall_tied got=%0d exp=0", stall); end
    tests++; if (fill !== 3'd0) begin fails++; $display("FAIL stats_fill_tied got=%0d exp=0", fill); end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_read_data();
    test_drain_release();
    test_wrap();
    test_reset_mid();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
